load_unit: RTL
==============

# load_unit

Load-side initiator for the word-organised data memory. Accepts one load request at a time from the core: word, halfword or byte, signed or unsigned. Issues the word read to the memory, then extracts and extends the addressed lane. Returns the result over a valid/ready response channel. It is the reader counterpart of the memory's sub-word write path, and uses the same size encoding and byte-lane layout.

## Interface
- `ADDR_W`, default 9: byte-address width. Bits `[ADDR_W-1:2]` select the word and bits `[1:0]` select the byte.
- `RD_LAT`, default 0: memory read latency in cycles, legal range 0..3. A value of 0 means combinational read data.
- `clk` input, 1 bit: clock, rising edge.
- `rstn` input, 1 bit: synchronous reset, active low.
- `req_valid` input, 1 bit: load request present.
- `req_ready` output, 1 bit: unit can accept a request.
- `req_addr` input, `ADDR_W` bits: byte address.
- `req_size` input, 2 bits: 2'b10 selects halfword, 2'b11 selects byte, any other value selects word.
- `req_signed` input, 1 bit: 1 sign-extends sub-word results, 0 zero-extends them.
- `rsp_valid` output, 1 bit: result valid.
- `rsp_ready` input, 1 bit: consumer accepts the result.
- `rsp_data` output, 32 bits: extracted and extended load value.
- `rsp_misalign` output, 1 bit: misaligned-access flag.
- `mem_addr` output, `ADDR_W` bits: address to the data memory.
- `mem_rd_en` output, 1 bit: read strobe.
- `mem_rd_data` input, 32 bits: word returned by the memory.

## Operation
- FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, latch addr, size and signed, clear the wait counter, and go to WAIT.
- WAIT:
  - `mem_rd_en`=1 and `mem_addr` = latched address.
  - The counter increments each cycle.
  - In the cycle where counter==`RD_LAT`, capture the extracted result into `rsp_data` and go to RESP.
- RESP:
  - `rsp_valid`=1, with `rsp_data` and `rsp_misalign` held stable.
  - On `rsp_ready`, go to IDLE.
  - No new request is accepted in the same cycle (`req_ready`=0 outside IDLE).
- Extraction, with lane = addr[1:0]:
  - Byte: `mem_rd_data[8*lane+7 : 8*lane]`.
  - Halfword: addr[1]=0 takes bits [15:0], addr[1]=1 takes bits [31:16].
  - Word: all 32 bits, with no extension.
- Sub-word results are extended to 32 bits according to the latched signed bit.
- Only one request is outstanding at a time; there is no request pipelining.

## Timing
- Reset values: state IDLE, `req_ready`=1 (after reset, since it is decoded from IDLE), `rsp_valid`=0, `rsp_data`=0, `rsp_misalign`=0, `mem_rd_en`=0, `mem_addr`=0.
- Latency: a request accepted at edge k gives `rsp_valid` high from edge k+2+`RD_LAT`.
- `rsp_valid` stays high until the edge where `rsp_ready`=1. The next acceptance is possible one cycle later at the earliest.
- Reset asserted in any state returns the FSM to IDLE at the next edge. An in-flight load is dropped and no response is produced.
- `mem_addr` changes only when entering WAIT.
- Outside WAIT, `mem_addr` holds its last value and `mem_rd_en`=0.

## Configuration
- Macro: `LOAD_UNIT_MISALIGN_EXC_EN`.
- With the macro defined, a misaligned access is detected at acceptance. Misaligned means halfword with addr[0]=1, or word with addr[1:0]≠0. For such an access:
  - The FSM goes directly IDLE→RESP.
  - `mem_rd_en` is never asserted.
  - The response carries `rsp_data`=0 and `rsp_misalign`=1.
  - Latency is 2 edges after acceptance.
- Without the macro:
  - `rsp_misalign` is tied to 0.
  - Halfword ignores addr[0]; word ignores addr[1:0].
  - All requests take the normal path.

## Structure
- Shared package `load_pkg`:
  - Size constants `SZ_HALF`=2'b10 and `SZ_BYTE`=2'b11.
  - FSM state typedef.
  - Misalign-detect function.
- Sub-module `load_aligner`: combinational. Inputs: word, addr[1:0], size, signed. Output: the extended 32-bit value. It is instantiated once and also reusable by the multi-cycle datapath.

## Test plan
- Preload the memory word at 0x004 with 0x8642A1F0 for all load checks.
- `RD_LAT`=0, byte signed at 0x007 → `rsp_data`=0xFFFFFF86, `rsp_valid` at edge k+2.
- Byte unsigned at 0x004 → 0x000000F0. Halfword signed at 0x006 → 0xFFFF8642. Halfword unsigned at 0x004 → 0x0000A1F0.
- Word at 0x004 with `RD_LAT`=3 → 0x8642A1F0 at edge k+5, with `mem_rd_en` high for exactly 4 cycles.
- Backpressure: hold `rsp_ready`=0 for 5 cycles → `rsp_valid` and `rsp_data` stable, `req_ready`=0 throughout.
- Word at 0x005 with the macro defined → `rsp_misalign`=1, `rsp_data`=0, `mem_rd_en` never high.
- Word at 0x005 without the macro → 0x8642A1F0, `rsp_misalign`=0.
- Reset pulsed during WAIT → next cycle is IDLE with `req_ready`=1. No `rsp_valid` ever appears for the dropped load, and a subsequent load completes correctly.

Source files
------------

// File: rtl/load_pkg.sv
// rtl/load_pkg.sv - shared size encodings, FSM states and misalign detect for the load unit
package load_pkg;

  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_BYTE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } load_state_t;

  // Bytes are always aligned; any size code that is not half/byte is a word.
  function automatic logic is_misaligned(input logic [1:0] lane, input logic [1:0] size);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = lane[0];
      default: is_misaligned = (lane != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_unit_if.sv
// rtl/load_unit_if.sv - request, response and memory-read signal bundle of the load unit
interface load_unit_if #(
  parameter int ADDR_W = 9
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_signed;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic              rsp_misalign;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [31:0]       mem_rd_data;

  // Environment side: core issuing loads plus the data memory answering reads.
  modport master (
    output req_valid, req_addr, req_size, req_signed, rsp_ready, mem_rd_data,
    input  req_ready, rsp_valid, rsp_data, rsp_misalign, mem_addr, mem_rd_en
  );

  modport slave (
    input  req_valid, req_addr, req_size, req_signed, rsp_ready, mem_rd_data,
    output req_ready, rsp_valid, rsp_data, rsp_misalign, mem_addr, mem_rd_en
  );
endinterface

// File: rtl/load_aligner.sv
// rtl/load_aligner.sv - combinational lane extraction and sign/zero extension of a read word
module load_aligner
  import load_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: data = {{24{is_signed & byte_sel[7]}}, byte_sel};
      SZ_HALF: data = {{16{is_signed & half_sel[15]}}, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// rtl/load_unit.sv - single-outstanding load initiator; LOAD_UNIT_MISALIGN_EXC_EN enables misalign trapping
module load_unit
  import load_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 0
) (
  input logic       clk,
  input logic       rstn,
  load_unit_if.slave bus
);

  localparam logic [1:0] LAT = 2'(RD_LAT);

  load_state_t       state;
  logic [1:0]        cnt;
  logic [1:0]        lane_q;
  logic [1:0]        size_q;
  logic              sign_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_data_q;
  logic              rsp_mis_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_rd_en_q;
  logic [31:0]       aligned;
  logic              mis_now;

`ifdef LOAD_UNIT_MISALIGN_EXC_EN
  assign mis_now = is_misaligned(bus.req_addr[1:0], bus.req_size);
`else
  assign mis_now = 1'b0;
`endif

  load_aligner u_aligner (
    .word      (bus.mem_rd_data),
    .lane      (lane_q),
    .size      (size_q),
    .is_signed (sign_q),
    .data      (aligned)
  );

  // In RESP the counter doubles as a settle timer so that rsp_valid rises one
  // edge after the normal capture and two edges after a trapped acceptance.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      cnt         <= 2'd0;
      lane_q      <= 2'd0;
      size_q      <= 2'd0;
      sign_q      <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_mis_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_en_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            lane_q      <= bus.req_addr[1:0];
            size_q      <= bus.req_size;
            sign_q      <= bus.req_signed;
            cnt         <= 2'd0;
            req_ready_q <= 1'b0;
            if (mis_now) begin
              rsp_data_q <= 32'd0;
              rsp_mis_q  <= 1'b1;
              state      <= ST_RESP;
            end else begin
              rsp_mis_q   <= 1'b0;
              mem_addr_q  <= bus.req_addr;
              mem_rd_en_q <= 1'b1;
              state       <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == LAT) begin
            rsp_data_q  <= aligned;
            mem_rd_en_q <= 1'b0;
            cnt         <= 2'd1;
            state       <= ST_RESP;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        ST_RESP: begin
          if (!rsp_valid_q) begin
            if (cnt == 2'd1) rsp_valid_q <= 1'b1;
            else             cnt         <= cnt + 2'd1;
          end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state       <= ST_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          mem_rd_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_misalign = rsp_mis_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_rd_en    = mem_rd_en_q;

endmodule
